// File: rtl/score_pkg.sv
// score_pkg: shared game-phase encoding and score bus defaults for the scorer and display driver.
package score_pkg;
  localparam int SCORE_W   = 8;
  localparam int MAX_SCORE = 99;
  localparam int BONUS_PTS = 5;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: game-event inputs and registered score outputs between game logic and scorer.
interface score_keeper_if;
  logic                          start;
  logic                          point;
  logic                          bonus;
  logic                          miss;
  logic                          clear_hi;
  logic [score_pkg::SCORE_W-1:0] score;
  logic [score_pkg::SCORE_W-1:0] hiscore;
  logic                          playing;
  logic                          game_over;
  logic                          new_hi;
  modport master (output start, point, bonus, miss, clear_hi,
                  input  score, hiscore, playing, game_over, new_hi);
  modport slave  (input  start, point, bonus, miss, clear_hi,
                  output score, hiscore, playing, game_over, new_hi);
endinterface

// File: rtl/score_keeper_sat_adder.sv
// sat_adder: adds the point/bonus increments to a score, clamped at MAX_SCORE.
module sat_adder #(
  parameter int MAX_SCORE = score_pkg::MAX_SCORE,
  parameter int BONUS_PTS = score_pkg::BONUS_PTS,
  parameter int SCORE_W   = score_pkg::SCORE_W
) (
  input  logic [SCORE_W-1:0] a_i,
  input  logic               point_i,
  input  logic               bonus_i,
  output logic [SCORE_W-1:0] sum_o
);
  logic [SCORE_W:0] sum;
  assign sum   = {1'b0, a_i} + (SCORE_W+1)'(point_i) + (bonus_i ? (SCORE_W+1)'(BONUS_PTS) : '0);
  assign sum_o = sum > (SCORE_W+1)'(MAX_SCORE) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
endmodule

// File: rtl/score_keeper.sv
// score_keeper: game-phase FSM that accumulates score and commits the high score at game over.
module score_keeper #(
  parameter int MAX_SCORE = score_pkg::MAX_SCORE,
  parameter int BONUS_PTS = score_pkg::BONUS_PTS,
  parameter int SCORE_W   = score_pkg::SCORE_W
) (
  input logic           clk,
  input logic           rst_n,
  score_keeper_if.slave bus
);
  import score_pkg::*;
  state_e               state_q;
  logic                 start_q;
  logic                 start_rise;
  logic                 new_hi_q;
  logic [SCORE_W-1:0]   score_q;
  logic [SCORE_W-1:0]   hiscore_q;
  logic [SCORE_W-1:0]   score_d;
  assign start_rise = bus.start & ~start_q;
  sat_adder #(.MAX_SCORE(MAX_SCORE), .BONUS_PTS(BONUS_PTS), .SCORE_W(SCORE_W)) u_add (
    .a_i     (score_q),
    .point_i (bus.point),
    .bonus_i (bus.bonus),
    .sum_o   (score_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      score_q   <= '0;
      hiscore_q <= '0;
      new_hi_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (bus.clear_hi) begin
            hiscore_q <= '0;
            new_hi_q  <= 1'b0;
          end
          if (start_rise) begin
            state_q  <= ST_PLAYING;
            score_q  <= '0;
            new_hi_q <= 1'b0;
          end
        end
        ST_PLAYING: begin
          score_q <= score_d;
          // commit uses the post-increment score so same-cycle points count
          if (bus.miss) begin
            state_q   <= ST_GAME_OVER;
            new_hi_q  <= score_d > hiscore_q;
            hiscore_q <= score_d > hiscore_q ? score_d : hiscore_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.score     = score_q;
  assign bus.hiscore   = hiscore_q;
  assign bus.new_hi    = new_hi_q;
  assign bus.playing   = state_q == ST_PLAYING;
  assign bus.game_over = state_q == ST_GAME_OVER;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed test-plan steps plus random event traffic against a rule-level model.
module tb_score_keeper;
  localparam int IDLE = 0, PLAY = 1, OVER = 2;
  localparam int MAXS = 99, BON = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  score_keeper_if bus();
  score_keeper dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int ph = IDLE, sc = 0, hi = 0, nh = 0, sp = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input bit s = 0, input bit p = 0, input bit b = 0,
                      input bit m = 0, input bit c = 0, input bit r = 1);
    bit rise;
    bus.start = s; bus.point = p; bus.bonus = b; bus.miss = m; bus.clear_hi = c; rst_n = r;
    @(posedge clk);
    rise = s && sp == 0;
    if (!r) begin
      ph = IDLE; sc = 0; hi = 0; nh = 0; sp = 0;
    end else begin
      sp = int'(s);
      if (ph == PLAY) begin
        sc = sc + int'(p) + BON * int'(b);
        if (sc > MAXS) sc = MAXS;
        if (m) begin
          ph = OVER;
          nh = int'(sc > hi);
          if (sc > hi) hi = sc;
        end
      end else begin
        if (c) begin hi = 0; nh = 0; end
        if (rise) begin ph = PLAY; sc = 0; nh = 0; end
      end
    end
    #1;
    chk("score", int'(bus.score), sc);
    chk("hiscore", int'(bus.hiscore), hi);
    chk("playing", int'(bus.playing), int'(ph == PLAY));
    chk("game_over", int'(bus.game_over), int'(ph == OVER));
    chk("new_hi", int'(bus.new_hi), nh);
    @(negedge clk);
  endtask
  initial begin
    bit lvl;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_state", int'({bus.playing, bus.game_over}), 0);
    tick(0, 1, 1, 1);
    chk("idle_pulses", int'(bus.score), 0);
    tick(1);
    chk("start_play", int'(bus.playing), 1);
    repeat (7) tick(1, 1);
    tick(0, 0, 0, 1);
    chk("g1_score", int'(bus.score), 7);
    chk("g1_hi", int'(bus.hiscore), 7);
    chk("g1_newhi", int'(bus.new_hi), 1);
    chk("g1_over", int'(bus.game_over), 1);
    repeat (100) tick();
    chk("g1_hold", int'(bus.score), 7);
    tick(1);
    repeat (3) tick(1, 1);
    tick(0, 0, 0, 1);
    chk("g2_score", int'(bus.score), 3);
    chk("g2_hi", int'(bus.hiscore), 7);
    chk("g2_newhi", int'(bus.new_hi), 0);
    tick(1);
    repeat (7) tick(0, 1);
    tick(0, 0, 0, 1);
    chk("g3_hi_eq", int'(bus.hiscore), 7);
    chk("g3_newhi", int'(bus.new_hi), 0);
    tick(1);
    repeat (19) tick(0, 0, 1);
    chk("sat_95", int'(bus.score), 95);
    tick(0, 1, 1);
    chk("sat_99", int'(bus.score), 99);
    repeat (3) tick(0, 1);
    chk("sat_hold", int'(bus.score), 99);
    tick(0, 0, 0, 1);
    chk("sat_hi", int'(bus.hiscore), 99);
    tick(0, 0, 0, 0, 1);
    chk("clr_over", int'(bus.hiscore), 0);
    tick(1);
    repeat (10) tick(0, 1);
    tick(0, 1, 0, 1);
    chk("sim_score", int'(bus.score), 11);
    chk("sim_over", int'(bus.game_over), 1);
    chk("sim_hi", int'(bus.hiscore), 11);
    tick(1);
    chk("hold_clear", int'(bus.score), 0);
    for (int i = 1; i < 50; i++) tick(1, i % 5 == 0);
    chk("hold_once", int'(bus.score), 9);
    tick(1, 0, 0, 1);
    tick(1, 1, 1);
    chk("over_pulses", int'(bus.score), 9);
    tick(0);
    tick(1);
    repeat (42) tick(1, 1);
    tick(1, 0, 0, 0, 1);
    chk("clr_play", int'(bus.hiscore), 11);
    chk("mid_42", int'(bus.score), 42);
    tick(0, 0, 0, 0, 0, 0);
    chk("mid_rst_score", int'(bus.score), 0);
    chk("mid_rst_hi", int'(bus.hiscore), 0);
    chk("mid_rst_idle", int'({bus.playing, bus.game_over}), 0);
    lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, 7) == 0) lvl = ~lvl;
      if (!r) lvl = 0;
      tick(lvl, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, r);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
